vend_dispense_sched: RTL and testbench
======================================

VEND_DISPENSE_SCHED -- requirements
Module: vend_dispense_sched

Interface
REQ-001 Parameter MOTOR_CYC, default 4: cycles the dispenser motor is driven per bottle.
REQ-002 Parameter SENSE_TMO, default 15: maximum cycles to wait for bottle_sense after motor stops.
REQ-003 Parameter COIN_GAP, default 2: low cycles after each coin_pulse.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_a / req_b  in  1  panel A/B requests the shared dispenser and change hopper.
REQ-007 vend_a / vend_b  in  1  bottle to dispense, sampled at grant.
REQ-008 chg_a / chg_b  in  2  change owed in 5 rs coins (0..3), sampled at grant.
REQ-009 bottle_sense  in  1  dispenser drop confirmation.
REQ-010 gnt_a / gnt_b  out  1  panel owns the resources.
REQ-011 done_a / done_b  out  1  one-cycle completion pulse.
REQ-012 motor  out  1  dispenser motor drive.
REQ-013 coin_pulse  out  1  hopper eject strobe, one 5 rs coin per high cycle.
REQ-014 fault  out  1  dispense failure indication.

Function
REQ-015 States SHALL be IDLE, MOTOR, SENSE, PAYOUT, GAP, DONE, FAULT.
REQ-016 Requests SHALL be sampled only in IDLE; req changes in any other state SHALL be ignored.
REQ-017 In IDLE with one request, that panel SHALL be selected; with both, the panel not served last SHALL be selected; the first arbitration after reset SHALL favour A.
REQ-018 On selection, vend/chg SHALL be latched and gnt_x SHALL assert the next cycle, holding until the cycle after DONE.
REQ-019 Next state from IDLE SHALL be MOTOR if vend=1, else PAYOUT if chg!=0, else DONE.
REQ-020 MOTOR SHALL hold motor=1 for exactly MOTOR_CYC cycles, then enter SENSE.
REQ-021 SENSE SHALL go to PAYOUT (chg!=0) or DONE (chg=0) on bottle_sense=1; after SENSE_TMO cycles without it, it SHALL go to FAULT.
REQ-022 bottle_sense outside SENSE SHALL be ignored.
REQ-023 PAYOUT SHALL assert coin_pulse for one cycle and decrement the latched count, then enter GAP.
REQ-024 GAP SHALL last COIN_GAP cycles, then return to PAYOUT if count!=0, else enter DONE.
REQ-025 DONE SHALL pulse done_x of the owner for one cycle, record the owner as last served, and return to IDLE.
REQ-026 FAULT SHALL hold fault=1, with gnt, motor and coin_pulse low and no done pulse.
REQ-027 gnt_a and gnt_b SHALL never both be 1; motor and coin_pulse SHALL never both be 1.
REQ-028 A request dropped mid-transaction SHALL still complete, including the done pulse.

Reset
REQ-029 rst SHALL force IDLE, clear the latched vend/chg and set last-served to B, from any state, including mid-motor or mid-payout.
REQ-030 Every output SHALL be 0 in the cycle after rst is sampled high.

Configuration
REQ-031 With VEND_FAULT_RECOVER_EN defined, an input fault_clr (1 bit) SHALL be added; fault_clr=1 in FAULT SHALL return to IDLE next cycle, with fault cleared and last-served set to the faulted panel.
REQ-032 Without VEND_FAULT_RECOVER_EN, FAULT SHALL be exited only by rst, and no fault_clr port SHALL exist.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum, the panel ID type (PANEL_A/PANEL_B) and the parameter defaults.
REQ-034 The two-way round-robin selection SHALL be a sub-module vend_rr_arb (inputs req_a, req_b, last; output sel, valid).

Verification
REQ-035 req_a=1, vend_a=1, chg_a=0, bottle_sense 2 cycles after motor falls -> gnt_a, motor high 4 cycles, done_a pulse, no coin_pulse.
REQ-036 req_a=req_b=1 in the same cycle from reset, both vend=1 with sense -> A served first, then B; the next simultaneous request serves A.
REQ-037 req_b=1, vend_b=0, chg_b=3 -> exactly 3 coin_pulse cycles spaced 3 cycles apart, then done_b.
REQ-038 vend_a=1, bottle_sense never asserted -> FAULT 15 cycles after motor falls, fault=1, no done_a; with the macro, fault_clr -> IDLE.
REQ-039 rst asserted during the second coin_pulse -> all outputs 0 next cycle; a new request is then served normally.

Source files
------------

// File: rtl/vend_dispense_sched_pkg.sv
// Shared types and parameter defaults for the vending dispense scheduler.
// Holds the FSM state encoding, the panel identifier and the timing defaults.
package vend_pkg;

  localparam int MOTOR_CYC_DEF = 4;
  localparam int SENSE_TMO_DEF = 15;
  localparam int COIN_GAP_DEF  = 2;
  localparam int CNT_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    SENSE,
    PAYOUT,
    GAP,
    DONE,
    FAULT
  } state_e;

  typedef enum logic {
    PANEL_A = 1'b0,
    PANEL_B = 1'b1
  } panel_e;

endpackage

// File: rtl/vend_dispense_sched_if.sv
// Panel/dispenser signal bundle between the two vending panels and the scheduler.
// VEND_FAULT_RECOVER_EN adds the fault_clr input.
interface vend_dispense_sched_if;

  logic       req_a;
  logic       req_b;
  logic       vend_a;
  logic       vend_b;
  logic [1:0] chg_a;
  logic [1:0] chg_b;
  logic       bottle_sense;
`ifdef VEND_FAULT_RECOVER_EN
  logic       fault_clr;
`endif
  logic       gnt_a;
  logic       gnt_b;
  logic       done_a;
  logic       done_b;
  logic       motor;
  logic       coin_pulse;
  logic       fault;

  modport master (
`ifdef VEND_FAULT_RECOVER_EN
    output fault_clr,
`endif
    output req_a, req_b, vend_a, vend_b, chg_a, chg_b, bottle_sense,
    input  gnt_a, gnt_b, done_a, done_b, motor, coin_pulse, fault
  );

  modport slave (
`ifdef VEND_FAULT_RECOVER_EN
    input  fault_clr,
`endif
    input  req_a, req_b, vend_a, vend_b, chg_a, chg_b, bottle_sense,
    output gnt_a, gnt_b, done_a, done_b, motor, coin_pulse, fault
  );

endinterface

// File: rtl/vend_dispense_sched_rr_arb.sv
// Two-way round-robin pick between panel A and panel B.
// When both request, the panel that was not served last wins.
module vend_rr_arb
  import vend_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  panel_e last,
  output panel_e sel,
  output logic   valid
);

  always_comb begin
    valid = req_a | req_b;
    if (req_a && req_b) begin
      sel = (last == PANEL_A) ? PANEL_B : PANEL_A;
    end else if (req_a) begin
      sel = PANEL_A;
    end else begin
      sel = PANEL_B;
    end
  end

endmodule

// File: rtl/vend_dispense_sched.sv
// Shared dispenser/change-hopper scheduler for two vending panels.
// Define VEND_FAULT_RECOVER_EN to allow leaving FAULT through fault_clr.
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter int MOTOR_CYC = MOTOR_CYC_DEF,
  parameter int SENSE_TMO = SENSE_TMO_DEF,
  parameter int COIN_GAP  = COIN_GAP_DEF
) (
  input logic                  clk,
  input logic                  rst,
  vend_dispense_sched_if.slave bus
);

  state_e           state_q;
  panel_e           owner_q;
  panel_e           last_q;
  logic             vend_q;
  logic [1:0]       chg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_a_q, gnt_b_q;
  logic             done_a_q, done_b_q;
  logic             motor_q, coin_q, fault_q;

  panel_e     arb_sel;
  logic       arb_valid;
  logic       sel_vend;
  logic [1:0] sel_chg;

  vend_rr_arb u_arb (
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .last  (last_q),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  assign sel_vend = (arb_sel == PANEL_A) ? bus.vend_a : bus.vend_b;
  assign sel_chg  = (arb_sel == PANEL_A) ? bus.chg_a  : bus.chg_b;

  // Outputs are registered for the state being entered, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= PANEL_A;
      last_q   <= PANEL_B;
      vend_q   <= 1'b0;
      chg_q    <= 2'd0;
      cnt_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      motor_q  <= 1'b0;
      coin_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      motor_q  <= 1'b0;
      coin_q   <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      fault_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            owner_q <= arb_sel;
            vend_q  <= sel_vend;
            chg_q   <= sel_chg;
            gnt_a_q <= (arb_sel == PANEL_A);
            gnt_b_q <= (arb_sel == PANEL_B);
            if (sel_vend) begin
              state_q <= MOTOR;
              motor_q <= 1'b1;
              cnt_q   <= CNT_W'(MOTOR_CYC - 1);
            end else if (sel_chg != 2'd0) begin
              state_q <= PAYOUT;
              coin_q  <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_a_q <= (arb_sel == PANEL_A);
              done_b_q <= (arb_sel == PANEL_B);
            end
          end
        end
        MOTOR: begin
          if (cnt_q == '0) begin
            state_q <= SENSE;
            cnt_q   <= CNT_W'(SENSE_TMO - 1);
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            motor_q <= vend_q;
          end
        end
        SENSE: begin
          // A drop seen in the last allowed cycle still beats the timeout.
          if (bus.bottle_sense) begin
            if (chg_q != 2'd0) begin
              state_q <= PAYOUT;
              coin_q  <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_a_q <= (owner_q == PANEL_A);
              done_b_q <= (owner_q == PANEL_B);
            end
          end else if (cnt_q == '0) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PAYOUT: begin
          chg_q   <= chg_q - 2'd1;
          cnt_q   <= CNT_W'(COIN_GAP - 1);
          state_q <= GAP;
        end
        GAP: begin
          if (cnt_q == '0) begin
            if (chg_q != 2'd0) begin
              state_q <= PAYOUT;
              coin_q  <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_a_q <= (owner_q == PANEL_A);
              done_b_q <= (owner_q == PANEL_B);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          last_q  <= owner_q;
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
        end
        FAULT: begin
`ifdef VEND_FAULT_RECOVER_EN
          if (bus.fault_clr) begin
            state_q <= IDLE;
            last_q  <= owner_q;
          end else begin
            fault_q <= 1'b1;
          end
`else
          fault_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.done_a     = done_a_q;
  assign bus.done_b     = done_b_q;
  assign bus.motor      = motor_q;
  assign bus.coin_pulse = coin_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Self-checking bench for vend_dispense_sched: directed scenarios plus randomized
// transactions compared cycle by cycle against a timeline model.
module tb_vend_dispense_sched;
  import vend_pkg::*;

  localparam int MC   = 4;
  localparam int ST   = 15;
  localparam int CG   = 2;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vend_dispense_sched_if bus ();

  vend_dispense_sched #(
    .MOTOR_CYC (MC),
    .SENSE_TMO (ST),
    .COIN_GAP  (CG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {gnt_a, gnt_b, done_a, done_b, motor, coin_pulse, fault} per cycle after grant
  logic [6:0] obs [MAXC];
  int         obs_len;
  bit         timed_out;
  panel_e     model_last;

  function automatic logic [6:0] out_vec();
    return {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.motor, bus.coin_pulse, bus.fault};
  endfunction

  function automatic panel_e model_pick(bit ra, bit rb, panel_e last);
    if (ra && rb) return (last == PANEL_A) ? PANEL_B : PANEL_A;
    return ra ? PANEL_A : PANEL_B;
  endfunction

  // Expected outputs k cycles after the grant edge, from the transaction timeline.
  function automatic logic [6:0] model_cycle(panel_e own, bit v, logic [1:0] c, int d, int k);
    int p, dn;
    logic [6:0] e;
    p  = v ? MC + d + 1 : 0;
    dn = p + int'(c) * (CG + 1);
    e  = '0;
    if (k <= dn) e[(own == PANEL_A) ? 6 : 5] = 1'b1;
    if (k == dn) e[(own == PANEL_A) ? 4 : 3] = 1'b1;
    if (v && k < MC) e[2] = 1'b1;
    if (k >= p && k < dn && ((k - p) % (CG + 1)) == 0) e[1] = 1'b1;
    return e;
  endfunction

  task automatic drive_txn(input bit ra, input bit rb, input bit va, input bit vb,
                           input logic [1:0] ca, input logic [1:0] cb,
                           input bit sel_vend, input int d, input bit noise, input int rst_at);
    int stop_at;
    stop_at = -1;
    @(negedge clk);
    bus.req_a = ra; bus.req_b = rb; bus.vend_a = va; bus.vend_b = vb;
    bus.chg_a = ca; bus.chg_b = cb; bus.bottle_sense = 1'b0;
    obs_len = 0;
    timed_out = 1'b0;
    for (int k = 0; k < MAXC; k++) begin
      @(negedge clk);
      obs[k] = out_vec();
      obs_len = k + 1;
      if (k == stop_at) break;
      if (stop_at < 0 && k == rst_at) begin
        rst = 1'b1;
        stop_at = k + 1;
      end
      if (stop_at < 0 && (bus.done_a || bus.done_b)) stop_at = k + 1;
      if (stop_at < 0 && bus.fault) stop_at = k + 3;
      bus.bottle_sense = 1'b0;
      if (sel_vend && d >= 0 && k == MC + d) bus.bottle_sense = 1'b1;
      else if (noise && (bus.motor || bus.coin_pulse)) bus.bottle_sense = 1'($urandom_range(0, 1));
      if (stop_at >= 0 || !noise) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end else begin
        bus.req_a  = 1'($urandom_range(0, 1));
        bus.req_b  = 1'($urandom_range(0, 1));
        bus.vend_a = 1'($urandom_range(0, 1));
        bus.vend_b = 1'($urandom_range(0, 1));
        bus.chg_a  = 2'($urandom_range(0, 3));
        bus.chg_b  = 2'($urandom_range(0, 3));
      end
    end
    if (stop_at < 0) timed_out = 1'b1;
    rst = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.bottle_sense = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_vec() !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", out_vec(), 7'b0);
    end
    rst = 1'b0;
    model_last = PANEL_B;
    @(negedge clk);
    n_cmp++;
    if (out_vec() !== 7'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want %b", out_vec(), 7'b0);
    end
  endtask

  task automatic test_single_vend();
    panel_e own;
    int n_motor, n_coin, n_done, n_gb;
    own = model_pick(1'b1, 1'b0, model_last);
    drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2, 1'b0, -1);
    n_motor = 0; n_coin = 0; n_done = 0; n_gb = 0;
    for (int k = 0; k < obs_len; k++) begin
      n_motor += int'(obs[k][2]);
      n_coin  += int'(obs[k][1]);
      n_done  += int'(obs[k][4]);
      n_gb    += int'(obs[k][5]);
    end
    n_cmp++;
    if (timed_out !== 1'b0) begin
      n_err++;
      $display("FAIL vend_a_timeout: got %0d want 0", timed_out);
    end
    n_cmp++;
    if (n_motor !== MC || obs[0][2] !== 1'b1 || obs[MC][2] !== 1'b0) begin
      n_err++;
      $display("FAIL vend_a_motor: got %0d cycles (first %b, after %b) want %0d from cycle 0",
               n_motor, obs[0][2], obs[MC][2], MC);
    end
    n_cmp++;
    if (n_coin !== 0) begin
      n_err++;
      $display("FAIL vend_a_coin: got %0d pulses want 0", n_coin);
    end
    n_cmp++;
    if (n_done !== 1 || obs[MC + 3][4] !== 1'b1) begin
      n_err++;
      $display("FAIL vend_a_done: got %0d pulses (at %0d: %b) want 1 at cycle %0d",
               n_done, MC + 3, obs[MC + 3][4], MC + 3);
    end
    n_cmp++;
    if (n_gb !== 0 || obs[0][6] !== 1'b1 || obs[MC + 3][6] !== 1'b1 || obs[MC + 4][6] !== 1'b0) begin
      n_err++;
      $display("FAIL vend_a_gnt: gnt_b %0d, gnt_a %b/%b/%b want 0, 1/1/0",
               n_gb, obs[0][6], obs[MC + 3][6], obs[MC + 4][6]);
    end
    model_last = own;
  endtask

  task automatic test_arbitration();
    panel_e own;
    int d, dn;
    logic [1:0] exp_g;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = PANEL_B;
    for (int i = 0; i < 3; i++) begin
      own = model_pick(1'b1, 1'b1, model_last);
      d = $urandom_range(0, 4);
      dn = MC + d + 1;
      exp_g = (own == PANEL_A) ? 2'b10 : 2'b01;
      drive_txn(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, d, 1'b0, -1);
      n_cmp++;
      if (obs[0][6:5] !== exp_g) begin
        n_err++;
        $display("FAIL arb_owner[%0d]: got gnt %b want %b", i, obs[0][6:5], exp_g);
      end
      n_cmp++;
      if (obs[dn][4:3] !== exp_g) begin
        n_err++;
        $display("FAIL arb_done[%0d]: got done %b at %0d want %b", i, obs[dn][4:3], dn, exp_g);
      end
      model_last = own;
    end
  endtask

  task automatic test_change();
    int coins[$];
    int n_motor, n_ga;
    drive_txn(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, -1, 1'b0, -1);
    n_motor = 0; n_ga = 0;
    for (int k = 0; k < obs_len; k++) begin
      if (obs[k][1]) coins.push_back(k);
      n_motor += int'(obs[k][2]);
      n_ga    += int'(obs[k][6]);
    end
    n_cmp++;
    if (coins.size() !== 3) begin
      n_err++;
      $display("FAIL change_count: got %0d coin pulses want 3", coins.size());
    end
    for (int i = 0; i < coins.size(); i++) begin
      n_cmp++;
      if (coins[i] !== i * (CG + 1)) begin
        n_err++;
        $display("FAIL change_spacing[%0d]: got cycle %0d want %0d", i, coins[i], i * (CG + 1));
      end
    end
    n_cmp++;
    if (obs[3 * (CG + 1)][3] !== 1'b1 || n_motor !== 0 || n_ga !== 0) begin
      n_err++;
      $display("FAIL change_done_b: done_b %b motor %0d gnt_a %0d want 1, 0, 0",
               obs[3 * (CG + 1)][3], n_motor, n_ga);
    end
    model_last = PANEL_B;
  endtask

  task automatic test_fault();
    panel_e own;
    int ff, n_done;
    own = model_pick(1'b1, 1'b0, model_last);
    drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, -1, 1'b1, -1);
    ff = -1; n_done = 0;
    for (int k = 0; k < obs_len; k++) begin
      if (ff < 0 && obs[k][0]) ff = k;
      n_done += int'(obs[k][4]) + int'(obs[k][3]);
    end
    n_cmp++;
    if (timed_out !== 1'b0 || ff !== MC + ST) begin
      n_err++;
      $display("FAIL fault_time: got first fault at %0d (timeout %0d) want %0d", ff, timed_out, MC + ST);
    end
    n_cmp++;
    if (obs[MC + ST - 1] !== 7'b1000000 || obs[MC + ST] !== 7'b0000001) begin
      n_err++;
      $display("FAIL fault_outputs: got %b then %b want 1000000 then 0000001",
               obs[MC + ST - 1], obs[MC + ST]);
    end
    n_cmp++;
    if (n_done !== 0 || obs[obs_len - 1] !== 7'b0000001) begin
      n_err++;
      $display("FAIL fault_hold: done pulses %0d, last %b want 0, 0000001", n_done, obs[obs_len - 1]);
    end
`ifdef VEND_FAULT_RECOVER_EN
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    n_cmp++;
    if (out_vec() !== 7'b0) begin
      n_err++;
      $display("FAIL fault_clr: got %b want %b", out_vec(), 7'b0);
    end
    model_last = own;
`else
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_vec() !== 7'b0000001) begin
      n_err++;
      $display("FAIL fault_sticky: got %b want %b", out_vec(), 7'b0000001);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_vec() !== 7'b0) begin
      n_err++;
      $display("FAIL fault_rst: got %b want %b", out_vec(), 7'b0);
    end
    model_last = PANEL_B;
`endif
  endtask

  task automatic test_reset_mid_payout();
    panel_e own;
    int bad;
    drive_txn(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, -1, 1'b0, CG + 1);
    n_cmp++;
    if (obs[CG + 1][1] !== 1'b1) begin
      n_err++;
      $display("FAIL second_coin: got %b want 1 at cycle %0d", obs[CG + 1][1], CG + 1);
    end
    n_cmp++;
    if (obs[CG + 2] !== 7'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %b want %b", obs[CG + 2], 7'b0);
    end
    model_last = PANEL_B;
    own = model_pick(1'b1, 1'b0, model_last);
    drive_txn(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, -1, 1'b0, -1);
    bad = 0;
    for (int k = 0; k < obs_len; k++)
      if (obs[k] !== model_cycle(own, 1'b0, 2'd1, 0, k)) bad++;
    n_cmp++;
    if (bad !== 0 || obs_len !== CG + 3) begin
      n_err++;
      $display("FAIL post_rst_txn: got %0d bad cycles, length %0d want 0, %0d", bad, obs_len, CG + 3);
    end
    model_last = own;
  endtask

  task automatic test_random();
    bit ra, rb, va, vb, v;
    logic [1:0] ca, cb, c;
    panel_e own;
    int d, dn;
    logic [6:0] e;
    for (int it = 0; it < 25; it++) begin
      do begin
        ra = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
      end while (!(ra || rb));
      va = 1'($urandom_range(0, 1));
      vb = 1'($urandom_range(0, 1));
      ca = 2'($urandom_range(0, 3));
      cb = 2'($urandom_range(0, 3));
      case (it % 3)
        0:       d = 0;
        1:       d = ST - 1;
        default: d = $urandom_range(0, ST - 1);
      endcase
      own = model_pick(ra, rb, model_last);
      v = (own == PANEL_A) ? va : vb;
      c = (own == PANEL_A) ? ca : cb;
      dn = (v ? MC + d + 1 : 0) + int'(c) * (CG + 1);
      drive_txn(ra, rb, va, vb, ca, cb, v, d, 1'b1, -1);
      n_cmp++;
      if (timed_out !== 1'b0 || obs_len !== dn + 2) begin
        n_err++;
        $display("FAIL rand_len[%0d]: got length %0d (timeout %0d) want %0d", it, obs_len, timed_out, dn + 2);
      end
      for (int k = 0; k < obs_len; k++) begin
        e = model_cycle(own, v, c, d, k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_err++;
          $display("FAIL rand_cycle[%0d][%0d]: got %b want %b (req %b%b vend %b chg %0d d %0d)",
                   it, k, obs[k], e, ra, rb, v, c, d);
        end
      end
      model_last = own;
    end
  endtask

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.vend_a = 1'b0; bus.vend_b = 1'b0;
    bus.chg_a = 2'd0; bus.chg_b = 2'd0; bus.bottle_sense = 1'b0;
`ifdef VEND_FAULT_RECOVER_EN
    bus.fault_clr = 1'b0;
`endif
    model_last = PANEL_B;
    test_reset();
    test_single_vend();
    test_arbitration();
    test_change();
    test_fault();
    test_reset_mid_payout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
